// File: rtl/lfsr_seq_ctrl_pkg.sv
// Shared definitions for the LFSR sequence controller: FSM encoding and
// default geometry.
package lfsr_seq_ctrl_pkg;

  localparam int unsigned LENGTH_DEFAULT      = 8;
  localparam int unsigned COUNT_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Bus bundle between a run requester/consumer (master) and the controller
// (slave).
//
// Handshake: a word moves on a rising Clock edge where Out_Valid and
// Out_Ready are both 1. While Out_Valid=1 and Out_Ready=0, Out_Data and
// Remaining hold. Out_Valid never depends combinationally on Out_Ready.
interface lfsr_seq_ctrl_if
  import lfsr_seq_ctrl_pkg::*;
#(
  parameter int unsigned Length      = LENGTH_DEFAULT,
  parameter int unsigned Count_Width = COUNT_WIDTH_DEFAULT
);

  logic                   Start;
  logic [Length-1:0]      Seed;
  logic [Length-1:0]      Taps;
  logic [Count_Width-1:0] Count;
  logic                   Abort;
  logic                   Out_Ready;
  logic                   Out_Valid;
  logic [Length-1:0]      Out_Data;
  logic                   Busy;
  logic                   Done;
  logic                   Error;
  logic [Count_Width-1:0] Remaining;

  modport master (
    output Start, Seed, Taps, Count, Abort, Out_Ready,
    input  Out_Valid, Out_Data, Busy, Done, Error, Remaining
  );

  modport slave (
    input  Start, Seed, Taps, Count, Abort, Out_Ready,
    output Out_Valid, Out_Data, Busy, Done, Error, Remaining
  );

endinterface

// File: rtl/lfsr_core.sv
// Galois-style LFSR register: state[Length-1] is cell 1, state[0] is cell
// Length. Load has priority over step.
module lfsr_core
  import lfsr_seq_ctrl_pkg::*;
#(
  parameter int unsigned Length = LENGTH_DEFAULT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic              step,
  input  logic [Length-1:0] seed,
  input  logic [Length-1:0] taps,
  output logic [Length-1:0] state
);

  logic [Length-1:0] state_q;
  logic [Length-1:0] state_d;
  logic [Length-1:0] step_val;
  logic              unused_tap0;

  // Cell Length feeds cell 1 and is XORed into every tapped cell on the way
  // down; taps[0] would address cell Length+1, which does not exist.
  assign unused_tap0 = taps[0];
  assign step_val = {state_q[0],
                     state_q[Length-1:1] ^ (taps[Length-1:1] & {(Length-1){state_q[0]}})};

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (step) begin
      state_d = step_val;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Run controller: captures Seed/Taps/Count on Start and streams Count LFSR
// words over a valid/ready port, with abort and zero-seed error handling.
module lfsr_seq_ctrl
  import lfsr_seq_ctrl_pkg::*;
#(
  parameter int unsigned Length      = LENGTH_DEFAULT,
  parameter int unsigned Count_Width = COUNT_WIDTH_DEFAULT
) (
  input  logic           Clock,
  input  logic           Reset,
  lfsr_seq_ctrl_if.slave bus,
  output state_e         dbg_state_o
);

  state_e                 state_q;
  logic [Length-1:0]      seed_q;
  logic [Length-1:0]      taps_q;
  logic [Count_Width-1:0] count_q;
  logic [Count_Width-1:0] remaining_q;
  logic                   out_valid_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   error_q;
  logic                   xfer;
  logic                   core_load;
  logic [Length-1:0]      lfsr_state;

  assign xfer      = out_valid_q & bus.Out_Ready;
  assign core_load = (state_q == LOAD);

  // Taps come from the shadow register so the polynomial cannot move mid-run.
  lfsr_core #(
    .Length (Length)
  ) u_core (
    .Clock (Clock),
    .Reset (Reset),
    .load  (core_load),
    .step  (xfer),
    .seed  (seed_q),
    .taps  (taps_q),
    .state (lfsr_state)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= IDLE;
      seed_q      <= '0;
      taps_q      <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.Start) begin
            seed_q  <= bus.Seed;
            taps_q  <= bus.Taps;
            count_q <= bus.Count;
            error_q <= (bus.Seed == '0);
            if ((bus.Seed == '0) || (bus.Count == '0)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= LOAD;
              busy_q  <= 1'b1;
            end
          end
        end
        LOAD: begin
          remaining_q <= count_q;
          if (bus.Abort) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q     <= RUN;
            out_valid_q <= 1'b1;
          end
        end
        RUN: begin
          if (xfer) begin
            remaining_q <= remaining_q - Count_Width'(1);
          end
          // An abort still lets a same-cycle transfer land.
          if (bus.Abort || (xfer && (remaining_q == Count_Width'(1)))) begin
            state_q     <= DONE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.Out_Valid = out_valid_q;
  assign bus.Out_Data  = lfsr_state;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Error     = error_q;
  assign bus.Remaining = remaining_q;
  assign dbg_state_o   = state_q;

endmodule
